// File: rtl/fire7_pkg.sv
// Shared fire7 constants and types: squeeze-layer geometry, RAM write payload, writer FSM states.
package fire7_pkg;

    localparam int unsigned FIRE7_WOUT      = 16;
    localparam int unsigned FIRE7_SQ_CH     = 64;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned FIRE7_SQ_ADDR_W = 14;
    localparam int unsigned FIRE7_SQ_PIX    = FIRE7_WOUT * FIRE7_WOUT;
    localparam int unsigned FIRE7_PIX_W     = $clog2(FIRE7_SQ_PIX);
    localparam int unsigned FIRE7_CH_W      = $clog2(FIRE7_SQ_CH);
    localparam int unsigned CKSUM_W         = 32;

    typedef logic [DATA_W-1:0] data_t;

    // One RAM write beat: address is {pixel, channel}
    typedef struct packed {
        logic [FIRE7_SQ_ADDR_W-1:0] addr;
        data_t                      data;
    } ram_wr_t;

    typedef enum logic [1:0] {WR_IDLE, WR_DRAIN, WR_DONE} wr_state_t;

endpackage

// File: rtl/fire7_squeeze_ofm_writer_if.sv
// Pixel-capture input and OFM RAM write port of the squeeze writer.
// checksum_o exists only when FIRE7_SQUEEZE_OFM_CHECKSUM_EN is defined.
interface fire7_squeeze_ofm_writer_if;
    import fire7_pkg::*;

    logic                       sample_i;
    data_t                      ofm_i [0:FIRE7_SQ_CH-1];
    logic                       wr_en_o;
    logic [FIRE7_SQ_ADDR_W-1:0] wr_addr_o;
    data_t                      wr_data_o;
    logic                       ram_feedback_o;
    logic                       overrun_o;
    logic                       busy_o;
`ifdef FIRE7_SQUEEZE_OFM_CHECKSUM_EN
    logic [CKSUM_W-1:0]         checksum_o;

    modport master (output sample_i, ofm_i,
                    input  wr_en_o, wr_addr_o, wr_data_o, ram_feedback_o, overrun_o, busy_o,
                           checksum_o);
    modport slave  (input  sample_i, ofm_i,
                    output wr_en_o, wr_addr_o, wr_data_o, ram_feedback_o, overrun_o, busy_o,
                           checksum_o);
`else
    modport master (output sample_i, ofm_i,
                    input  wr_en_o, wr_addr_o, wr_data_o, ram_feedback_o, overrun_o, busy_o);
    modport slave  (input  sample_i, ofm_i,
                    output wr_en_o, wr_addr_o, wr_data_o, ram_feedback_o, overrun_o, busy_o);
`endif

endinterface

// File: rtl/fire7_ofm_capture_buf.sv
// Parallel-load bank holding one pixel's channel outputs, read back one channel at a time.
module fire7_ofm_capture_buf
    import fire7_pkg::*;
(
    input  logic                  clk,
    input  logic                  load_i,
    input  data_t                 d_i [0:FIRE7_SQ_CH-1],
    input  logic [FIRE7_CH_W-1:0] rd_idx_i,
    output data_t                 rd_data_c_o
);

    data_t buf_q [0:FIRE7_SQ_CH-1];

    // Contents are don't-care after reset, so the bank carries no reset
    always_ff @(posedge clk) begin
        if (load_i) begin
            buf_q <= d_i;
        end
    end

    assign rd_data_c_o = buf_q[rd_idx_i];

endmodule

// File: rtl/fire7_squeeze_ofm_writer.sv
// Serialises captured squeeze pixels into the OFM RAM, channel per cycle, pixel-major.
// Optional running checksum of written data under FIRE7_SQUEEZE_OFM_CHECKSUM_EN.
module fire7_squeeze_ofm_writer
    import fire7_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    fire7_squeeze_ofm_writer_if.slave  bus
);

    localparam int unsigned CH_W     = FIRE7_CH_W;
    localparam int unsigned PIX_W    = FIRE7_PIX_W;
    localparam int unsigned LAST_CH  = FIRE7_SQ_CH - 1;
    localparam int unsigned LAST_PIX = FIRE7_SQ_PIX - 1;

    wr_state_t         state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    ram_wr_t           wr_q, wr_d;
    logic              wr_en_q, wr_en_d;
    logic              fb_q, fb_d;
    logic              ovr_q, ovr_d;

    logic              load_c;
    logic              last_ch_c;
    logic [CH_W-1:0]   ch_inc_c;
    logic [PIX_W-1:0]  pix_inc_c;
    data_t             rd_data_c;

    assign last_ch_c = (ch_q == CH_W'(LAST_CH));
    assign ch_inc_c  = ch_q + CH_W'(1);
    assign pix_inc_c = pix_q + PIX_W'(1);

    fire7_ofm_capture_buf u_buf (
        .clk         (clk),
        .load_i      (load_c),
        .d_i         (bus.ofm_i),
        .rd_idx_i    (ch_inc_c),
        .rd_data_c_o (rd_data_c)
    );

    // ch_q is the channel currently on the write port; a fresh pixel writes ch 0 straight from ofm_i
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pix_d   = pix_q;
        wr_d    = wr_q;
        wr_en_d = 1'b0;
        fb_d    = fb_q;
        ovr_d   = ovr_q;
        load_c  = 1'b0;

        case (state_q)
            WR_IDLE: begin
                if (bus.sample_i) begin
                    load_c       = 1'b1;
                    state_d      = WR_DRAIN;
                    ch_d         = '0;
                    wr_en_d      = 1'b1;
                    wr_d.addr    = {pix_q, CH_W'(0)};
                    wr_d.data    = bus.ofm_i[0];
                end
            end
            WR_DRAIN: begin
                if (!last_ch_c) begin
                    ch_d      = ch_inc_c;
                    wr_en_d   = 1'b1;
                    wr_d.addr = {pix_q, ch_inc_c};
                    wr_d.data = rd_data_c;
                    ovr_d     = ovr_q | bus.sample_i;
                end else begin
                    pix_d = pix_inc_c;
                    ch_d  = '0;
                    if (pix_q == PIX_W'(LAST_PIX)) begin
                        state_d = WR_DONE;
                        fb_d    = 1'b1;
                    end else if (bus.sample_i) begin
                        load_c    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_d.addr = {pix_inc_c, CH_W'(0)};
                        wr_d.data = bus.ofm_i[0];
                    end else begin
                        state_d = WR_IDLE;
                    end
                end
            end
            WR_DONE: begin
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WR_IDLE;
            ch_q    <= '0;
            pix_q   <= '0;
            wr_q    <= '0;
            wr_en_q <= 1'b0;
            fb_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pix_q   <= pix_d;
            wr_q    <= wr_d;
            wr_en_q <= wr_en_d;
            fb_q    <= fb_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.wr_en_o        = wr_en_q;
    assign bus.busy_o         = wr_en_q;
    assign bus.wr_addr_o      = wr_q.addr;
    assign bus.wr_data_o      = wr_q.data;
    assign bus.ram_feedback_o = fb_q;
    assign bus.overrun_o      = ovr_q;

`ifdef FIRE7_SQUEEZE_OFM_CHECKSUM_EN
    logic [CKSUM_W-1:0] cks_q;

    // Accumulates the beat on the port; no writes in DONE keeps it frozen there
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cks_q <= '0;
        end else if (wr_en_q) begin
            cks_q <= cks_q + CKSUM_W'(wr_q.data);
        end
    end

    assign bus.checksum_o = cks_q;
`endif

endmodule
